// File: rtl/hamming_uart_tx.sv
// UART transmitter for Hamming(8,4) codewords: a small FIFO buffers accepted words,
// and each word goes out as start, 8 data bits LSB first, optional even parity, then stop bits.
module hamming_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    code_in,
  input  logic                          code_valid,
  output logic                          code_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    idx_q, idx_d;
  logic          stop_q, stop_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;

  logic push, pop, done, baud_last;

  // Ready depends only on the registered count, never on code_valid.
  assign code_ready = (count_q != CW'(FIFO_DEPTH));
  assign push       = code_valid && code_ready;
  assign baud_last  = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= code_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    sh_d    = sh_q;
    pop     = 1'b0;
    done    = 1'b0;
    tx_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          sh_d    = mem_q[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (idx_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          stop_d  = 1'b0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is registered from the next state so tx changes cleanly at the edge.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh_d[idx_d];
      S_PARITY: tx_d = ^sh_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      stop_q  <= 1'b0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign tx_done    = done;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_hamming_uart_tx.sv
// Directed bench for hamming_uart_tx: three instances cover plain framing,
// even parity and two stop bits, all at 4 clocks per bit.
module tb_hamming_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] code_w  [3];
  logic       valid_w [3];
  logic       ready_w [3];
  logic       tx_w    [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  logic [2:0] cnt_w   [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hamming_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .code_in(code_w[0]), .code_valid(valid_w[0]), .code_ready(ready_w[0]),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]), .fifo_count(cnt_w[0]));

  hamming_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(1), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .code_in(code_w[1]), .code_valid(valid_w[1]), .code_ready(ready_w[1]),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]), .fifo_count(cnt_w[1]));

  hamming_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .PARITY_EN(0), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .code_in(code_w[2]), .code_valid(valid_w[2]), .code_ready(ready_w[2]),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]), .fifo_count(cnt_w[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word for a single edge, then one more edge so the frame has started.
  task automatic send_one(input int d, input logic [7:0] w);
    code_w[d]  = w;
    valid_w[d] = 1'b1;
    tick();
    valid_w[d] = 1'b0;
    tick();
  endtask

  // f holds the frame bits in line order (bit 0 = start bit); 4 cycles per bit.
  task automatic check_frame(input int d, input string tag, input logic [11:0] f, input int nb);
    for (int i = 0; i < nb * 4; i++) begin
      chk($sformatf("%s_tx%0d", tag, i), 32'(tx_w[d]), 32'(f[i / 4]));
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy_w[d]), 32'd1);
      chk($sformatf("%s_done%0d", tag, i), 32'(done_w[d]), (i == nb * 4 - 1) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  initial begin
    logic [7:0] words [6];
    int         acc, nrx, rc, full_edge, low_seen;
    logic       rx_act, take;
    logic [7:0] rx_word;

    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      code_w[d]  = '0;
      valid_w[d] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_tx%0d", d),    32'(tx_w[d]),   32'd1);
      chk($sformatf("rst_busy%0d", d),  32'(busy_w[d]), 32'd0);
      chk($sformatf("rst_done%0d", d),  32'(done_w[d]), 32'd0);
      chk($sformatf("rst_cnt%0d", d),   32'(cnt_w[d]),  32'd0);
      chk($sformatf("rst_ready%0d", d), 32'(ready_w[d]), 32'd1);
    end

    // Single frame: word is buffered one cycle before the FSM picks it up.
    code_w[0]  = 8'hA6;
    valid_w[0] = 1'b1;
    tick();
    valid_w[0] = 1'b0;
    chk("t1_cnt_after_push", 32'(cnt_w[0]), 32'd1);
    chk("t1_tx_idle",        32'(tx_w[0]),  32'd1);
    chk("t1_busy_idle",      32'(busy_w[0]), 32'd0);
    tick();
    chk("t1_cnt_after_pop",  32'(cnt_w[0]), 32'd0);
    check_frame(0, "t1", {2'b00, 1'b1, 8'hA6, 1'b0}, 10);
    chk("t1_end_tx",   32'(tx_w[0]),   32'd1);
    chk("t1_end_busy", 32'(busy_w[0]), 32'd0);
    chk("t1_end_done", 32'(done_w[0]), 32'd0);

    // Back-to-back 00 then FF with exactly one idle cycle in between.
    code_w[0]  = 8'h00;
    valid_w[0] = 1'b1;
    tick();
    code_w[0] = 8'hFF;
    tick();
    valid_w[0] = 1'b0;
    chk("t4_cnt_pushpop", 32'(cnt_w[0]), 32'd1);
    check_frame(0, "t4a", {2'b00, 1'b1, 8'h00, 1'b0}, 10);
    chk("t4_gap_tx",   32'(tx_w[0]),   32'd1);
    chk("t4_gap_busy", 32'(busy_w[0]), 32'd0);
    chk("t4_gap_cnt",  32'(cnt_w[0]),  32'd1);
    tick();
    check_frame(0, "t4b", {2'b00, 1'b1, 8'hFF, 1'b0}, 10);
    chk("t4_end_busy", 32'(busy_w[0]), 32'd0);

    // Six words with valid held high; a simple receiver checks order on the line.
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h96;
    acc = 0; nrx = 0; rc = 0; full_edge = 0; rx_act = 1'b0; rx_word = '0;
    for (int c = 1; c <= 400 && nrx < 6; c++) begin
      valid_w[0] = (acc < 6);
      code_w[0]  = (acc < 6) ? words[acc] : 8'h00;
      take = valid_w[0] && ready_w[0];
      tick();
      if (take) acc++;
      chk($sformatf("t3_cnt_le4_c%0d", c), 32'(cnt_w[0] <= 3'd4), 32'd1);
      if (!ready_w[0] && full_edge == 0) begin
        full_edge = c;
        chk("t3_full_cnt", 32'(cnt_w[0]), 32'd4);
        chk("t3_full_acc", 32'(acc), 32'd5);
      end
      if (!rx_act && tx_w[0] == 1'b0) begin
        rx_act = 1'b1;
        rc     = 0;
      end
      if (rx_act) begin
        if (rc == 2) chk($sformatf("t3_start%0d", nrx), 32'(tx_w[0]), 32'd0);
        for (int j = 1; j <= 8; j++)
          if (rc == 4 * j + 2) rx_word[j - 1] = tx_w[0];
        if (rc == 39) begin
          chk($sformatf("t3_stop%0d", nrx), 32'(tx_w[0]), 32'd1);
          chk($sformatf("t3_done%0d", nrx), 32'(done_w[0]), 32'd1);
          chk($sformatf("t3_word%0d", nrx), 32'(rx_word), 32'(words[nrx]));
          nrx++;
          rx_act = 1'b0;
        end
        rc++;
      end
    end
    valid_w[0] = 1'b0;
    chk("t3_full_edge", 32'(full_edge), 32'd5);
    chk("t3_accepted",  32'(acc), 32'd6);
    chk("t3_received",  32'(nrx), 32'd6);
    tick();
    chk("t3_end_busy", 32'(busy_w[0]), 32'd0);

    // Reset in the middle of a data bit with two words still queued.
    code_w[0]  = 8'h5A;
    valid_w[0] = 1'b1;
    tick();
    code_w[0] = 8'h3C;
    tick();
    code_w[0] = 8'hC3;
    tick();
    valid_w[0] = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t5_pre_busy", 32'(busy_w[0]), 32'd1);
    chk("t5_pre_cnt",  32'(cnt_w[0]),  32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_tx",    32'(tx_w[0]),    32'd1);
    chk("t5_busy",  32'(busy_w[0]),  32'd0);
    chk("t5_cnt",   32'(cnt_w[0]),   32'd0);
    chk("t5_done",  32'(done_w[0]),  32'd0);
    chk("t5_ready", 32'(ready_w[0]), 32'd1);
    low_seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) low_seen++;
    end
    chk("t5_quiet", 32'(low_seen), 32'd0);

    // Even parity: A6 has four ones (parity 0), 07 has three ones (parity 1).
    send_one(1, 8'hA6);
    check_frame(1, "t2a", {1'b0, 1'b1, 1'b0, 8'hA6, 1'b0}, 11);
    chk("t2a_end_busy", 32'(busy_w[1]), 32'd0);
    send_one(1, 8'h07);
    check_frame(1, "t2b", {1'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    chk("t2b_end_tx", 32'(tx_w[1]), 32'd1);

    // Two stop bits: stop phase spans 8 cycles, done on the last one.
    send_one(2, 8'hA6);
    check_frame(2, "t6", {1'b0, 2'b11, 8'hA6, 1'b0}, 11);
    chk("t6_end_busy", 32'(busy_w[2]), 32'd0);
    chk("t6_end_done", 32'(done_w[2]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
